// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor: one (g,p) stage, LOG2W registered prefix levels,
// and one sum stage, all advancing together under a single valid/ready stall.
module pipelined_prefix_adder #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int LOG2W = $clog2(WIDTH);

  // index 0 is the (g,p) stage, index l is prefix level l
  logic [LOG2W:0]                  v_q, v_d;
  logic [LOG2W:0]                  cin_q, cin_d;
  logic [LOG2W:0][WIDTH-1:0]       g_q, g_d;
  logic [LOG2W:0][WIDTH-1:0]       p_q, p_d;
  logic [LOG2W:0][WIDTH-1:0]       x_q, x_d;
  logic [LOG2W:0][TAG_W-1:0]       tg_q, tg_d;

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] carry;

  always_comb begin
    advance = !ov_q || out_ready;
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_sub | in_cin;
    carry   = {g_q[LOG2W][WIDTH-2:0], cin_q[LOG2W]};

    v_d    = v_q;
    cin_d  = cin_q;
    g_d    = g_q;
    p_d    = p_q;
    x_d    = x_q;
    tg_d   = tg_q;
    ov_d   = ov_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    otag_d = otag_q;

    if (advance) begin
      v_d[0]   = in_valid;
      cin_d[0] = cin_eff;
      x_d[0]   = in_a ^ b_eff;
      g_d[0]   = in_a & b_eff;
      p_d[0]   = in_a ^ b_eff;
      // bit 0 absorbs the carry-in, so its group signal is fully resolved
      g_d[0][0] = (in_a[0] & b_eff[0]) | ((in_a[0] ^ b_eff[0]) & cin_eff);
      p_d[0][0] = 1'b0;
      tg_d[0]  = in_tag;

      for (int l = 1; l <= LOG2W; l++) begin
        v_d[l]   = v_q[l-1];
        cin_d[l] = cin_q[l-1];
        x_d[l]   = x_q[l-1];
        tg_d[l]  = tg_q[l-1];
        for (int j = 0; j < (1 << (l-1)); j++) begin
          g_d[l][j] = g_q[l-1][j];
          p_d[l][j] = p_q[l-1][j];
        end
        for (int j = (1 << (l-1)); j < WIDTH; j++) begin
          g_d[l][j] = g_q[l-1][j] | (p_q[l-1][j] & g_q[l-1][j-(1 << (l-1))]);
          p_d[l][j] = p_q[l-1][j] & p_q[l-1][j-(1 << (l-1))];
        end
      end

      ov_d   = v_q[LOG2W];
      sum_d  = x_q[LOG2W] ^ carry;
      cout_d = g_q[LOG2W][WIDTH-1];
      ovf_d  = g_q[LOG2W][WIDTH-1] ^ g_q[LOG2W][WIDTH-2];
      otag_d = tg_q[LOG2W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      cin_q  <= '0;
      g_q    <= '0;
      p_q    <= '0;
      x_q    <= '0;
      tg_q   <= '0;
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      otag_q <= '0;
    end else begin
      v_q    <= v_d;
      cin_q  <= cin_d;
      g_q    <= g_d;
      p_q    <= p_d;
      x_q    <= x_d;
      tg_q   <= tg_d;
      ov_q   <= ov_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      otag_q <= otag_d;
    end
  end

  assign in_ready  = !ov_q || out_ready;
  assign out_valid = ov_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_tag   = otag_q;
  assign busy      = (|v_q) || ov_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and random checks of the pipelined prefix adder at WIDTH=32: latency,
// arithmetic, full-rate streaming, backpressure freeze/ordering and mid-flight reset.
module tb_pipelined_prefix_adder;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [TW-1:0] out_tag;
  logic          busy;

  pipelined_prefix_adder #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // operation table with expected results
  logic [W-1:0]  oa [128];
  logic [W-1:0]  ob [128];
  logic          oc [128];
  logic          osb[128];
  logic [TW-1:0] ot [128];
  logic [W-1:0]  es [128];
  logic          ec [128];
  logic          ev [128];

  int n_ops = 0;
  int sent  = 0;
  int cyc   = 0;
  int last_len = 0;
  int qi[$];
  int qc[$];
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_sum;
  logic [TW-1:0] prev_tag;

  task automatic set_dir(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic [TW-1:0] t,
                         input logic [W-1:0] xs, input logic xc, input logic xv);
    oa[i] = a; ob[i] = b; oc[i] = c; osb[i] = s; ot[i] = t;
    es[i] = xs; ec[i] = xc; ev[i] = xv;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic [TW-1:0] t);
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   r;
    bb = s ? ~b : b;
    ci = s ? 1'b1 : c;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    set_dir(i, a, b, c, s, t, r[W-1:0], r[W], (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]));
  endtask

  task automatic cycle(input bit rdy, input bit lat);
    int idx;
    int ac;
    @(negedge clk);
    out_ready = rdy;
    if (sent < n_ops) begin
      in_valid = 1'b1;
      in_a = oa[sent]; in_b = ob[sent]; in_cin = oc[sent]; in_sub = osb[sent]; in_tag = ot[sent];
    end else begin
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_tag = '0;
    end
    #1;
    if (prev_stall) begin
      chk("frozen_valid", out_valid, 1);
      chk("frozen_sum", out_sum, prev_sum);
      chk("frozen_tag", out_tag, prev_tag);
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      if (qi.size() == 0) begin
        chk("stale_out_valid", out_valid, 0);
      end else begin
        idx = qi.pop_front();
        ac  = qc.pop_front();
        chk("sum", out_sum, es[idx]);
        chk("cout", out_cout, ec[idx]);
        chk("ovf", out_ovf, ev[idx]);
        chk("tag", out_tag, ot[idx]);
        if (lat) chk("latency", cyc - ac - 1, LAT);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_sum   = out_sum;
    prev_tag   = out_tag;
    if (in_valid && in_ready) begin
      qi.push_back(sent);
      qc.push_back(cyc);
      sent++;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int stall_from, input int stall_len, input bit lat);
    int n;
    n = 0;
    sent = 0;
    prev_stall = 1'b0;
    while ((sent < n_ops || qi.size() > 0) && n < 2000) begin
      cycle(!(n >= stall_from && n < stall_from + stall_len), lat);
      n++;
    end
    chk("run_complete", qi.size() + (n_ops - sent), 0);
    last_len = n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_sum", out_sum, 0);
    chk("idle_tag", out_tag, 0);

    // carry ripples the full width
    set_dir(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'hA, 32'h0000_0000, 1'b1, 1'b0);
    n_ops = 1;
    run(0, 0, 1'b1);

    // signed overflow, then subtraction with borrow (cin ignored)
    set_dir(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h3, 32'h8000_0000, 1'b0, 1'b1);
    set_dir(1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'h4, 32'hFFFF_FFFE, 1'b0, 1'b0);
    set_dir(2, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 4'h5, 32'h9999_999A, 1'b0, 1'b0);
    set_dir(3, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h6, 32'h7FFF_FFFF, 1'b1, 1'b1);
    set_dir(4, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 4'h7, 32'h0000_0000, 1'b1, 1'b0);
    set_dir(5, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 4'h8, 32'h0000_0001, 1'b1, 1'b1);
    n_ops = 6;
    run(0, 0, 1'b1);

    // 100 back-to-back random ops at full rate
    for (int i = 0; i < 100; i++)
      set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
    n_ops = 100;
    run(0, 0, 1'b1);
    chk("b2b_cycles", last_len, 100 + LAT + 1);

    // backpressure mid-stream: tags 0..15 must each emerge once, in order
    for (int i = 0; i < 16; i++)
      set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
    n_ops = 16;
    run(8, 10, 1'b0);
    chk("bp_cycles", last_len, 16 + LAT + 1 + 10);

    // reset with 4 ops in flight, one of them held at the output
    set_dir(0, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0, 4'h9, 32'h0000_0002, 1'b1, 1'b0);
    set_op(1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 4'hB);
    set_op(2, 32'h0000_3333, 32'h0000_0001, 1'b0, 1'b1, 4'hC);
    set_op(3, 32'h7000_0000, 32'h7000_0000, 1'b0, 1'b0, 4'hD);
    n_ops = 4;
    sent = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_sum", out_sum, 32'h0000_0002);
    chk("pre_reset_busy", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sum", out_sum, 0);
    chk("arst_cout", out_cout, 0);
    chk("arst_ovf", out_ovf, 0);
    chk("arst_tag", out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    qi.delete();
    qc.delete();
    n_ops = 0;
    sent = 0;
    prev_stall = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0);
      #1;
      chk("post_reset_valid", out_valid, 0);
      chk("post_reset_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
